mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mux2.sv | 11 +
 rtl/mem_port_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory port arbiter.
package mem_arb_pkg;
  localparam int DEF_WIDTH      = 64;
  localparam int DEF_AW         = 64;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} arb_state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
  parameter int WIDTH = mem_arb_pkg::DEF_WIDTH,
  parameter int AW    = mem_arb_pkg::DEF_AW
);
  logic             if_req;
  logic [AW-1:0]    if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic             d_req;
  logic             d_we;
  logic [AW-1:0]    d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mux2.sv
// Two-input bus selector.
module mux2 #(
  parameter int W = 64
) (
  input  logic         sel,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  output logic [W-1:0] y
);
  assign y = sel ? a1 : a0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch and a data requester onto one memory port, data first,
// with a starvation bound that forces a pending fetch through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int AW         = DEF_AW,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q;
  logic [CW-1:0]    starve_q;
  logic [AW-1:0]    if_addr_q, d_addr_q;
  logic [WIDTH-1:0] d_wdata_q, rdata_q;
  logic             we_q;
  logic             idle, busy, starved, d_win, if_win;

  assign idle    = (state_q == IDLE);
  assign busy    = (state_q == BUSY_IF) || (state_q == BUSY_D);
  assign starved = bus.if_req && (starve_q == CW'(STARVE_MAX));
  assign d_win   = idle && bus.d_req && !starved;
  assign if_win  = idle && bus.if_req && !d_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grants are gated by rst_n so they drop immediately while reset is held.
  always_comb begin
    state_d       = state_q;
    bus.if_gnt    = if_win && rst_n;
    bus.d_gnt     = d_win && rst_n;
    bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    bus.d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
    bus.mem_req   = busy;
    bus.mem_we    = (state_q == BUSY_D) && we_q;
    unique case (state_q)
      IDLE:            if (d_win) state_d = BUSY_D;
                       else if (if_win) state_d = BUSY_IF;
      BUSY_IF, BUSY_D: if (bus.mem_ready) state_d = RESP;
      RESP:            state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_IF;
      starve_q  <= '0;
      if_addr_q <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (d_win) begin
        owner_q   <= OWN_D;
        d_addr_q  <= bus.d_addr;
        d_wdata_q <= bus.d_wdata;
        we_q      <= bus.d_we;
        if (!bus.if_req)                        starve_q <= '0;
        else if (starve_q != CW'(STARVE_MAX))   starve_q <= starve_q + CW'(1);
      end else if (if_win) begin
        owner_q   <= OWN_IF;
        if_addr_q <= bus.if_addr;
        we_q      <= 1'b0;
        starve_q  <= '0;
      end
      if (busy && bus.mem_ready) rdata_q <= bus.mem_rdata;
    end
  end

  mux2 #(.W(AW)) u_addr_mux (
    .sel(owner_q == OWN_D), .a0(if_addr_q), .a1(d_addr_q), .y(bus.mem_addr)
  );
  mux2 #(.W(WIDTH)) u_wdata_mux (
    .sel(owner_q == OWN_D), .a0('0), .a1(d_wdata_q), .y(bus.mem_wdata)
  );

  assign bus.if_rdata = rdata_q;
  assign bus.d_rdata  = rdata_q;
endmodule
